// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner: sequences MULT/MULTU through a fixed-latency multiplier,
// DIV/DIVU through a radix-2 restoring divider, and MTHI/MTLO as direct writes.
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        req_cancel,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  localparam int unsigned CW = (MUL_LAT > 32) ? $clog2(MUL_LAT) : 5;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q;
  logic          done_q;
  logic [63:0]   prod_q;
  logic [31:0]   rem_q, quo_q, dsr_q, src1_q;
  logic          negq_q, negr_q, dz_q;

  logic          accept, sgn_mul, sgn_div;
  logic [63:0]   mul_a, mul_b, prod_d;
  logic [31:0]   mag1, mag2;
  logic [32:0]   shift;
  logic [31:0]   diff, rem_d, quo_d;

  assign req_ready = (state_q == IDLE) && !req_cancel;
  assign accept    = req_valid && req_ready && (req_op <= 3'd5);

  // Low 64 bits of a product of 64-bit extended operands are the exact
  // signed or unsigned 32x32 product.
  assign sgn_mul = (req_op == 3'd0);
  assign mul_a   = {{32{sgn_mul & req_src1[31]}}, req_src1};
  assign mul_b   = {{32{sgn_mul & req_src2[31]}}, req_src2};
  assign prod_d  = mul_a * mul_b;

  // Magnitudes held as unsigned 32-bit, so |0x80000000| stays exact.
  assign sgn_div = (req_op == 3'd2);
  assign mag1    = (sgn_div && req_src1[31]) ? 32'(0) - req_src1 : req_src1;
  assign mag2    = (sgn_div && req_src2[31]) ? 32'(0) - req_src2 : req_src2;

  // Partial remainder is always below the divisor, so the shifted value fits 33 bits.
  assign shift = {rem_q, quo_q[31]};
  assign diff  = shift[31:0] - dsr_q;
  always_comb begin
    rem_d = shift[31:0];
    quo_d = {quo_q[30:0], 1'b0};
    if (shift >= {1'b0, dsr_q}) begin
      rem_d = diff;
      quo_d = {quo_q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      src1_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (req_op)
              3'd0, 3'd1: begin
                prod_q  <= prod_d;
                cnt_q   <= CW'(MUL_LAT - 1);
                state_q <= MUL;
              end
              3'd2, 3'd3: begin
                quo_q   <= mag1;
                dsr_q   <= mag2;
                rem_q   <= '0;
                src1_q  <= req_src1;
                negq_q  <= sgn_div & (req_src1[31] ^ req_src2[31]);
                negr_q  <= sgn_div & req_src1[31];
                dz_q    <= (req_src2 == '0);
                cnt_q   <= '0;
                state_q <= DIV;
              end
              3'd4:    hi_q <= req_src1;
              3'd5:    lo_q <= req_src1;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (req_cancel) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            {hi_q, lo_q} <= prod_q;
            done_q       <= 1'b1;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIV: begin
          if (req_cancel) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == CW'(31)) state_q <= FIX;
            else                  cnt_q   <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          if (!req_cancel) begin
            lo_q   <= dz_q ? '1     : (negq_q ? 32'(0) - quo_q : quo_q);
            hi_q   <= dz_q ? src1_q : (negr_q ? 32'(0) - rem_q : rem_q);
            done_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
